adc_dac_bridge: RTL
===================

ADC_DAC_BRIDGE -- requirements
Module: adc_dac_bridge

Interface
REQ-001 SHALL have parameter IN_W, default 12, the input sample width.
REQ-002 SHALL have parameter OUT_W, default 14, the output sample width.
REQ-003 SHALL have parameter NUM_CH, default 4, the channel count; CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter DEPTH, default 16, the FIFO depth (power of two, at least 2).
REQ-005 SHALL have parameter MODE, default 0:
- 0 = straight mapping.
- 1 = output MSB inverted (offset-binary to two's complement).
REQ-006 SHALL have parameter STRETCH_CYC, default 1048575, the activity-stretch length in clock cycles.
REQ-007 SHALL have parameter HB_DIV, default 25000000, the heartbeat half-period in cycles.
REQ-008 Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  IN_W  sample.
- s_axis_tuser  in  CH_W  channel id.
- s_axis_tvalid  in  1.
- s_axis_tready  out  1.
- m_axis_tdata  out  OUT_W  mapped sample.
- m_axis_tdest  out  CH_W  channel id.
- m_axis_tvalid  out  1.
- m_axis_tready  in  1.
- ch_en  in  NUM_CH  per-channel enable.
- fifo_level  out  clog2(DEPTH)+1  occupancy.
- drop_cnt  out  16  dropped-sample count.
- in_act  out  1  input activity indicator.
- out_act  out  1  output activity indicator.
- heartbeat  out  1  square wave.

Function
REQ-009 SHALL accept an input beat on any cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-010 SHALL drive s_axis_tready from a register equal to (fifo_level < DEPTH) after the current cycle's push and pop.
- A push into a full FIFO SHALL never occur.
- Simultaneous push and pop SHALL leave the level unchanged.
REQ-011 An accepted beat with tuser >= NUM_CH, or with ch_en[tuser] = 0, SHALL be discarded without entering the FIFO.
- Each discard SHALL increment drop_cnt, saturating at 16'hFFFF.
REQ-012 Width mapping SHALL be applied before storage:
- OUT_W >= IN_W: out = {in, (OUT_W-IN_W) zeros}.
- OUT_W < IN_W: out = in[IN_W-1 -: OUT_W].
REQ-013 When MODE = 1, the output MSB SHALL be inverted after mapping.
REQ-014 The FIFO SHALL be circular with DEPTH entries of {tdest, tdata}; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 m_axis_tvalid SHALL assert on the clock edge following the accept of a stored beat into an empty FIFO (latency 1 cycle).
REQ-016 m_axis_tdata and m_axis_tdest SHALL stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.
- A pop SHALL occur only when both are 1.
REQ-017 Output order SHALL equal acceptance order across all channels.
REQ-018 fifo_level SHALL equal the stored-beat count; m_axis_tvalid = (fifo_level != 0).
REQ-019 A changing ch_en SHALL affect only beats accepted on or after the cycle it changes; stored beats SHALL still be output.
REQ-020 in_act SHALL reload a counter to STRETCH_CYC on each accepted input beat and decrement it to 0 otherwise; in_act = (counter != 0).
REQ-021 out_act SHALL behave the same way, triggered by output pops.
REQ-022 heartbeat SHALL toggle every HB_DIV cycles.

Reset
REQ-023 While rst_n = 0, the block SHALL hold these values:
- s_axis_tready = 0, m_axis_tvalid = 0.
- m_axis_tdata = 0, m_axis_tdest = 0.
- fifo_level = 0, drop_cnt = 0.
- in_act = 0, out_act = 0, heartbeat = 0.
- All pointers and counters = 0.
REQ-024 s_axis_tready SHALL rise on the first clk edge after rst_n deasserts.
REQ-025 Reset asserted mid-transfer SHALL discard all FIFO contents immediately (asynchronously).

Configuration
REQ-026 Macro ADC_DAC_BRIDGE_STATUS_EN:
- Defined: drop_cnt, in_act, out_act and heartbeat SHALL be implemented per REQ-011 and REQ-020..022.
- Undefined: those outputs SHALL be tied to 0 with no counters synthesised.
- Datapath and dropping behaviour SHALL be identical in both cases.

Verification
REQ-027 Defaults, ch_en=4'hF, send 12'hABC on ch 2, m_axis_tready=1 -> next cycle m_axis_tdata=14'h2AF0, tdest=2.
REQ-028 m_axis_tready=0, push 17 beats -> 16 stored, s_axis_tready=0 after the 16th, fifo_level=16; release tready -> 16 beats out in order, values intact.
REQ-029 ch_en=4'b1011, send one beat per ch 0..3 -> ch 2 absent from output, drop_cnt=1.
REQ-030 MODE=1, IN_W=OUT_W=12, input 12'h800 -> output 12'h000; input 12'h000 -> output 12'h800.
REQ-031 Continuous push/pop at level 8 for 100 cycles -> level stays 8; assert rst_n=0 mid-stream -> all outputs 0 at once, s_axis_tready=1 one edge after release.
REQ-032 STRETCH_CYC=10, single input beat -> in_act high for exactly 10 cycles; with the macro undefined -> in_act, drop_cnt and heartbeat constant 0.

Source files
------------

// File: rtl/adc_dac_bridge.sv
// adc_dac_bridge: AXI-Stream ADC-to-DAC sample bridge with a per-channel
// filter, width/format mapping, a circular FIFO and optional status outputs.
// Ports: clk, rst_n (async, active-low);
//   s_axis_* : sample in (tdata, tuser = channel id, tvalid, tready)
//   m_axis_* : mapped sample out (tdata, tdest = channel id, tvalid, tready)
//   ch_en    : per-channel enable; fifo_level : stored-beat count
//   drop_cnt, in_act, out_act, heartbeat : status outputs
// Macro ADC_DAC_BRIDGE_STATUS_EN builds the status logic; otherwise the
// status outputs are tied to 0.
module adc_dac_bridge #(
    parameter int IN_W        = 12,
    parameter int OUT_W       = 14,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 16,
    parameter int MODE        = 0,
    parameter int STRETCH_CYC = 1048575,
    parameter int HB_DIV      = 25000000,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic [CH_W-1:0]  s_axis_tuser,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic [CH_W-1:0]  m_axis_tdest,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [LW-1:0]    fifo_level,
    output logic [15:0]      drop_cnt,
    output logic             in_act,
    output logic             out_act,
    output logic             heartbeat
);

    localparam logic [OUT_W-1:0] MSB_MASK =
        (MODE == 1) ? (OUT_W'(1) << (OUT_W - 1)) : '0;

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic                  rdy_q;
    logic [CH_W+OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0]      map_raw, map_d;
    logic                  accept, ch_ok, push, pop;

    // Width mapping: left-justify when widening, keep MSBs when narrowing.
    if (OUT_W >= IN_W) begin : g_pad
        assign map_raw = OUT_W'(s_axis_tdata) << (OUT_W - IN_W);
    end else begin : g_trunc
        assign map_raw = s_axis_tdata[IN_W-1 -: OUT_W];
    end

    assign map_d = map_raw ^ MSB_MASK;

    always_comb begin
        ch_ok = 1'b0;
        if (32'(s_axis_tuser) < NUM_CH) ch_ok = ch_en[s_axis_tuser];
    end

    assign accept = s_axis_tvalid & rdy_q;
    assign push   = accept & ch_ok;
    assign pop    = m_axis_tvalid & m_axis_tready;
    assign level_d = level_q + LW'(push) - LW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            rdy_q   <= (level_d < LW'(DEPTH));
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_axis_tuser, map_d};
    end

    assign s_axis_tready = rdy_q;
    assign fifo_level    = level_q;
    assign m_axis_tvalid = (level_q != '0);
    assign {m_axis_tdest, m_axis_tdata} =
        m_axis_tvalid ? mem_q[rd_ptr_q] : '0;

`ifdef ADC_DAC_BRIDGE_STATUS_EN
    localparam int SW = (STRETCH_CYC > 0) ? $clog2(STRETCH_CYC + 1) : 1;
    localparam int HW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    logic [15:0]   drop_q;
    logic [SW-1:0] in_cnt_q, out_cnt_q;
    logic [HW-1:0] hb_cnt_q;
    logic          hb_q;
    logic          drop;

    assign drop = accept & ~ch_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            hb_cnt_q  <= '0;
            hb_q      <= 1'b0;
        end else begin
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            if (accept)
                in_cnt_q <= SW'(STRETCH_CYC);
            else if (in_cnt_q != '0)
                in_cnt_q <= in_cnt_q - SW'(1);
            if (pop)
                out_cnt_q <= SW'(STRETCH_CYC);
            else if (out_cnt_q != '0)
                out_cnt_q <= out_cnt_q - SW'(1);
            if (hb_cnt_q == HW'(HB_DIV - 1)) begin
                hb_cnt_q <= '0;
                hb_q     <= ~hb_q;
            end else begin
                hb_cnt_q <= hb_cnt_q + HW'(1);
            end
        end
    end

    assign drop_cnt  = drop_q;
    assign in_act    = (in_cnt_q != '0);
    assign out_act   = (out_cnt_q != '0);
    assign heartbeat = hb_q;
`else
    assign drop_cnt  = 16'd0;
    assign in_act    = 1'b0;
    assign out_act   = 1'b0;
    assign heartbeat = 1'b0;
`endif

endmodule
